sound_generator_burst: RTL and testbench
========================================

Name: sound_generator_burst

Overview:
Parametrised successor to the single-tone sound generator. Produces a square wave with a programmable period and high time (duty cycle). Plays it as a burst pattern: N tone bursts separated by silent gaps, then signals completion. Sits between a melody/alert sequencer and the buzzer pin driver.

Parameters:
CLOCK_HZ, 10_000_000, system clock frequency; must be a multiple of 1_000_000 and at least 1_000_000
DURATION_W, 16, width of Duration_ms_i and Gap_ms_i
PERIOD_W, 16, width of Period_us_i and HighTime_us_i
REPEAT_W, 8, width of Repeat_i

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start_i  in  1  request; sampled only while Busy_o=0
Finish_i  in  1  abort request; acted on only while Busy_o=1
Duration_ms_i  in  DURATION_W  tone time per burst, in ms
Gap_ms_i  in  DURATION_W  silence between bursts, in ms
Period_us_i  in  PERIOD_W  full wave period, in us
HighTime_us_i  in  PERIOD_W  high part of each period, in us
Repeat_i  in  REPEAT_W  extra bursts; total bursts = Repeat_i+1
SoundWave_o  out  1  buzzer drive
Busy_o  out  1  pattern in progress
Done_o  out  1  one-cycle completion or abort pulse

Behaviour:
- Reset low: state IDLE; SoundWave_o=0, Busy_o=0, Done_o=0; all counters cleared. Takes effect immediately, including mid-burst.
- States: IDLE, TONE, GAP, DONE. Busy_o=1 only in TONE and GAP.
- Start_i=1 at edge k while in IDLE or DONE:
  - latch all *_i operands and reset the us prescaler;
  - from edge k+1: state TONE, Busy_o=1.
  - Operands may change or be X after edge k.
- Start_i while Busy_o=1 is ignored.
- Timebase: us tick every CLOCK_HZ/1_000_000 clocks; ms tick every 1000 us ticks. The prescaler restarts at each state entry, so each phase lasts exactly Duration*CLOCK_HZ/1000 clocks (or Gap*CLOCK_HZ/1000 clocks).
- TONE:
  - A period counter runs in us. SoundWave_o=1 during the first HighTime us of each period, 0 for the rest. It restarts at 0 on every TONE entry, so every burst begins with a high phase.
  - Silence (SoundWave_o=0 for the whole burst) if Period=0, HighTime=0, or HighTime>=Period.
  - At the end of Duration: if bursts remain and Gap>0, go to GAP; if bursts remain and Gap=0, enter TONE again; otherwise go to DONE.
- GAP: SoundWave_o=0 for Gap ms, then TONE. The burst counter increments when TONE is entered.
- DONE: lasts one cycle. Done_o=1, Busy_o=0, SoundWave_o=0. Next state is IDLE, or TONE if Start_i=1 that cycle (back-to-back start).
- Duration=0: TONE is skipped. Edge k+1 enters DONE, so Done_o=1 one cycle after Start and Busy_o never rises. Repeat and Gap are ignored.
- Finish_i=1 in TONE or GAP: next edge enters DONE. SoundWave_o drops to 0 that same edge; Done_o pulses. Finish_i in IDLE or DONE is ignored. If Start_i and Finish_i are both high in IDLE, Start is accepted.
- Counters: duration and gap counters are DURATION_W+1 bits of ms; period counter is PERIOD_W bits of us; burst counter is REPEAT_W bits and compares against the latched Repeat. No wrap is possible.

Optional Feature:
Macro SOUND_GENERATOR_BURST_COUNT_EN.
- Defined: adds output port BurstIndex_o [REPEAT_W]. It shows the 0-based index of the current burst: 0 on entering TONE after Start, +1 on each later TONE entry. It holds its value through DONE and is cleared by reset or a new Start.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- 10 MHz; Duration=1, Period=20, HighTime=10, Gap=0, Repeat=0, Start at edge k -> SoundWave alternates 100 clocks high / 100 clocks low for 50 periods; Done pulse at edge k+10001; Busy high edges k+1..k+10000.
- Duration=2, Period=100, HighTime=25, Gap=1, Repeat=2 -> three 25% duty bursts of 20000 clocks, each followed by 10000 silent clocks except the last; Done at k+80001; BurstIndex 0,1,2 (macro on).
- Duration=0, Period=99 -> Done at k+1, Busy and SoundWave stay 0; Start issued the same cycle as Done is accepted.
- Period=0 with Duration=2, then Period=10/HighTime=10 with Duration=2 -> SoundWave constant 0; Done at k+20001 in both cases.
- Duration=10, Period=500, HighTime=250; Finish after 50000 clocks -> SoundWave=0 and Done=1 on the next edge, Busy=0; further Finish pulses ignored; Start pulse during Busy ignored (no restart).
- Reset low mid-TONE while SoundWave=1 -> all outputs 0 immediately, before the next clock edge; after release, a new Start behaves as in scenario 1.

Source files
------------

// File: rtl/sound_generator_burst.sv
// Burst-pattern square-wave generator: Repeat+1 tone bursts of programmable period/duty, separated by gaps.
// Optional macro SOUND_GENERATOR_BURST_COUNT_EN adds BurstIndex_o (0-based index of the current burst).
module sound_generator_burst #(
  parameter int CLOCK_HZ   = 10_000_000,
  parameter int DURATION_W = 16,
  parameter int PERIOD_W   = 16,
  parameter int REPEAT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start_i,
  input  logic                  Finish_i,
  input  logic [DURATION_W-1:0] Duration_ms_i,
  input  logic [DURATION_W-1:0] Gap_ms_i,
  input  logic [PERIOD_W-1:0]   Period_us_i,
  input  logic [PERIOD_W-1:0]   HighTime_us_i,
  input  logic [REPEAT_W-1:0]   Repeat_i,
`ifdef SOUND_GENERATOR_BURST_COUNT_EN
  output logic [REPEAT_W-1:0]   BurstIndex_o,
`endif
  output logic                  SoundWave_o,
  output logic                  Busy_o,
  output logic                  Done_o
);
  localparam int US_DIV = CLOCK_HZ / 1_000_000;
  localparam int US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int MS_W   = DURATION_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [DURATION_W-1:0] dur_q, dur_d, gap_q, gap_d;
  logic [PERIOD_W-1:0]   per_q, per_d, high_q, high_d;
  logic [REPEAT_W-1:0]   rep_q, rep_d, burst_q, burst_d;
  logic [US_W-1:0]       us_cnt_q, us_cnt_d;
  logic [9:0]            ms_us_q, ms_us_d;
  logic [MS_W-1:0]       ms_cnt_q, ms_cnt_d;
  logic [PERIOD_W-1:0]   per_cnt_q, per_cnt_d;

  logic            accept, busy, us_tick, ms_tick, phase_end, more, restart, tone_reentry;
  logic [MS_W-1:0] phase_len;

  always_comb begin
    accept    = Start_i && (state_q == S_IDLE || state_q == S_DONE);
    busy      = (state_q == S_TONE) || (state_q == S_GAP);
    us_tick   = busy && (us_cnt_q == US_W'(US_DIV - 1));
    ms_tick   = us_tick && (ms_us_q == 10'd999);
    phase_len = (state_q == S_TONE) ? {1'b0, dur_q} : {1'b0, gap_q};
    phase_end = ms_tick && ((ms_cnt_q + MS_W'(1)) == phase_len);
    more      = (burst_q != rep_q);
    // Every state entry (including TONE->TONE) restarts the timebase.
    restart   = accept || (busy && (Finish_i || phase_end));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = (Duration_ms_i == '0) ? S_DONE : S_TONE;
        else        state_d = S_IDLE;
      end
      S_TONE: begin
        if (Finish_i)       state_d = S_DONE;
        else if (phase_end) state_d = !more ? S_DONE : ((gap_q != '0) ? S_GAP : S_TONE);
      end
      S_GAP: begin
        if (Finish_i)       state_d = S_DONE;
        else if (phase_end) state_d = S_TONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy_o      = busy;
    Done_o      = (state_q == S_DONE);
    // Out-of-range duty (Period=0, HighTime=0 or HighTime>=Period) keeps the pin silent.
    SoundWave_o = (state_q == S_TONE) && (high_q < per_q) && (per_cnt_q < high_q);
  end

`ifdef SOUND_GENERATOR_BURST_COUNT_EN
  assign BurstIndex_o = burst_q;
`endif

  always_comb begin
    tone_reentry = busy && !Finish_i && phase_end && (state_d == S_TONE);
    dur_d     = dur_q;
    gap_d     = gap_q;
    per_d     = per_q;
    high_d    = high_q;
    rep_d     = rep_q;
    burst_d   = burst_q;
    us_cnt_d  = us_cnt_q;
    ms_us_d   = ms_us_q;
    ms_cnt_d  = ms_cnt_q;
    per_cnt_d = per_cnt_q;

    if (accept) begin
      dur_d   = Duration_ms_i;
      gap_d   = Gap_ms_i;
      per_d   = Period_us_i;
      high_d  = HighTime_us_i;
      rep_d   = Repeat_i;
      burst_d = '0;
    end else if (tone_reentry) begin
      burst_d = burst_q + REPEAT_W'(1);
    end

    if (restart) begin
      us_cnt_d  = '0;
      ms_us_d   = '0;
      ms_cnt_d  = '0;
      per_cnt_d = '0;
    end else if (busy) begin
      us_cnt_d = us_tick ? '0 : us_cnt_q + US_W'(1);
      if (us_tick) begin
        ms_us_d = (ms_us_q == 10'd999) ? 10'd0 : ms_us_q + 10'd1;
        if (state_q == S_TONE)
          per_cnt_d = ((per_cnt_q + PERIOD_W'(1)) == per_q) ? '0 : per_cnt_q + PERIOD_W'(1);
      end
      if (ms_tick) ms_cnt_d = ms_cnt_q + MS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_q     <= '0;
      gap_q     <= '0;
      per_q     <= '0;
      high_q    <= '0;
      rep_q     <= '0;
      burst_q   <= '0;
      us_cnt_q  <= '0;
      ms_us_q   <= '0;
      ms_cnt_q  <= '0;
      per_cnt_q <= '0;
    end else begin
      dur_q     <= dur_d;
      gap_q     <= gap_d;
      per_q     <= per_d;
      high_q    <= high_d;
      rep_q     <= rep_d;
      burst_q   <= burst_d;
      us_cnt_q  <= us_cnt_d;
      ms_us_q   <= ms_us_d;
      ms_cnt_q  <= ms_cnt_d;
      per_cnt_q <= per_cnt_d;
    end
  end

endmodule

// File: tb/tb_sound_generator_burst.sv
// Bench for sound_generator_burst at 2 MHz (2 clocks per us) to keep run length short.
// Per-cycle outputs are compared against a phase-arithmetic model of the burst pattern.
module tb_sound_generator_burst;
  localparam int CLOCK_HZ = 2_000_000;
  localparam int CPU      = CLOCK_HZ / 1_000_000;
  localparam int DW = 16, PW = 16, RW = 8;

  logic clk = 0, rst_n = 0, start = 0, finish = 0;
  logic [DW-1:0] dur = 0, gap = 0;
  logic [PW-1:0] per = 0, hi = 0;
  logic [RW-1:0] rep = 0;
  logic wave, busy, done;
`ifdef SOUND_GENERATOR_BURST_COUNT_EN
  logic [RW-1:0] bidx;
`endif
  int cyc = 0, errors = 0, checks = 0;

  sound_generator_burst #(.CLOCK_HZ(CLOCK_HZ), .DURATION_W(DW), .PERIOD_W(PW), .REPEAT_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .Start_i(start), .Finish_i(finish),
    .Duration_ms_i(dur), .Gap_ms_i(gap), .Period_us_i(per), .HighTime_us_i(hi), .Repeat_i(rep),
`ifdef SOUND_GENERATOR_BURST_COUNT_EN
    .BurstIndex_o(bidx),
`endif
    .SoundWave_o(wave), .Busy_o(busy), .Done_o(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct { bit wave; bit busy; bit done; int idx; } exp_t;

  function automatic longint total_len(input int d, input int g, input int r);
    longint tone, gp;
    tone = longint'(d) * CPU * 1000;
    gp   = longint'(g) * CPU * 1000;
    if (d == 0) return 1;
    return (r + 1) * tone + r * gp + 1;
  endfunction

  // t = cycles since the edge that accepted Start (t=1 is the first cycle after it).
  function automatic exp_t ref_out(input longint t, input int d, input int g, input int p,
                                   input int h, input int r, input int fin_at);
    exp_t e;
    longint tone, gp, pos;
    e = '{0, 0, 0, -1};
    tone = longint'(d) * CPU * 1000;
    gp   = longint'(g) * CPU * 1000;
    if (d == 0) begin
      e.done = (t == 1);
      if (t == 1) e.idx = 0;
      return e;
    end
    if (fin_at > 0 && t > fin_at) begin
      e.done = (t == fin_at + 1);
      return e;
    end
    pos = t - 1;
    for (int b = 0; b <= r; b++) begin
      if (pos < tone) begin
        e.busy = 1;
        e.idx  = b;
        if (h < p) e.wave = (((pos / CPU) % p) < h);
        return e;
      end
      pos -= tone;
      if (b < r) begin
        if (pos < gp) begin
          e.busy = 1;
          e.idx  = b;
          return e;
        end
        pos -= gp;
      end
    end
    e.done = (pos == 0);
    return e;
  endfunction

  task automatic run(input string name, input int d, input int g, input int p, input int h,
                     input int r, input int fin_at, input int ign_at,
                     output int done_t, output int busy_n, output int high_n);
    int k, mism, first_bad, last_idx, len;
    exp_t e;
    len = (fin_at > 0) ? fin_at + 12 : int'(total_len(d, g, r)) + 3;
    @(posedge clk); #1;
    start = 1; dur = DW'(d); gap = DW'(g); per = PW'(p); hi = PW'(h); rep = RW'(r);
    k = cyc;
    done_t = -1; busy_n = 0; high_n = 0; mism = 0; first_bad = -1; last_idx = 0;
    for (int t = 1; t <= len; t++) begin
      @(posedge clk); #1;
      start  = (t == ign_at);
      finish = (fin_at > 0) && (t == fin_at || t == fin_at + 5 || t == fin_at + 10);
      if (t == 1) begin
        dur = DW'($urandom); gap = DW'($urandom); per = PW'($urandom);
        hi = PW'($urandom); rep = RW'($urandom);
      end
      @(negedge clk);
      e = ref_out(cyc - k, d, g, p, h, r, fin_at);
      if (wave !== e.wave || busy !== e.busy || done !== e.done) begin
        mism++;
        if (first_bad < 0) first_bad = t;
      end
`ifdef SOUND_GENERATOR_BURST_COUNT_EN
      if (e.busy) last_idx = e.idx;
      if ((e.busy || e.done) && bidx !== RW'((e.idx >= 0) ? e.idx : last_idx)) begin
        mism++;
        if (first_bad < 0) first_bad = t;
      end
`endif
      if (done === 1'b1 && done_t < 0) done_t = t;
      if (busy === 1'b1) busy_n++;
      if (wave === 1'b1) high_n++;
    end
    start = 0; finish = 0;
    if (mism != 0) $display("note %s: first divergent cycle t=%0d", name, first_bad);
    check({name, " trace_mismatches"}, mism, 0);
  endtask

  typedef struct { int d; int g; int p; int h; int r; int exp_done; int exp_busy; int exp_high; } vec_t;
  vec_t tbl[5];

  initial begin
    int dt, bn, hn, k, n;
    int rd, rg, rp, rh, rr;

    tbl[0] = '{1, 0, 20, 10, 0,  2001,  2000, 1000};
    tbl[1] = '{2, 1, 100, 25, 2, 16001, 16000, 3000};
    tbl[2] = '{0, 0, 99, 5, 0,   1,     0,     0};
    tbl[3] = '{2, 0, 0, 0, 0,    4001,  4000,  0};
    tbl[4] = '{2, 0, 10, 10, 0,  4001,  4000,  0};

    #12;
    check("reset wave", wave, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk); rst_n = 1;

    foreach (tbl[i]) begin
      run($sformatf("vec%0d", i), tbl[i].d, tbl[i].g, tbl[i].p, tbl[i].h, tbl[i].r, 0, 0, dt, bn, hn);
      check($sformatf("vec%0d done_at", i), dt, tbl[i].exp_done);
      check($sformatf("vec%0d busy_cycles", i), bn, tbl[i].exp_busy);
      check($sformatf("vec%0d high_cycles", i), hn, tbl[i].exp_high);
    end

    // Abort mid-tone while high; an ignored Start during Busy and repeated Finish pulses afterwards.
    run("finish", 10, 0, 500, 250, 0, 5200, 3000, dt, bn, hn);
    check("finish done_at", dt, 5201);
    check("finish busy_cycles", bn, 5200);
    check("finish high_cycles", hn, 2700);

    // Zero duration then back-to-back Start during the Done cycle.
    @(posedge clk); #1;
    start = 1; dur = 0; per = 99; hi = 5; gap = 0; rep = 0;
    @(posedge clk); #1;
    check("b2b done", done, 1);
    check("b2b busy_in_done", busy, 0);
    check("b2b wave_in_done", wave, 0);
    dur = 1; per = 4; hi = 2;
    @(posedge clk); #1;
    start = 0;
    check("b2b busy", busy, 1);
    check("b2b wave", wave, 1);
    n = 0;
    while (n < 2100) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) break;
    end
    check("b2b done_after", n, 2000);

    // Asynchronous reset mid-tone while the wave is high.
    @(posedge clk); #1;
    start = 1; dur = 1; per = 20; hi = 10; gap = 0; rep = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset wave", wave, 1);
    #2 rst_n = 0;
    #1;
    check("async_reset wave", wave, 0);
    check("async_reset busy", busy, 0);
    check("async_reset done", done, 0);
    @(negedge clk); rst_n = 1;
    run("post_reset", 1, 0, 20, 10, 0, 0, 0, dt, bn, hn);
    check("post_reset done_at", dt, 2001);
    check("post_reset high_cycles", hn, 1000);

    for (int i = 0; i < 4; i++) begin
      rd = 1; rg = $urandom_range(1, 0); rr = $urandom_range(1, 0);
      rp = $urandom_range(12, 0); rh = $urandom_range(13, 0);
      run($sformatf("rand%0d", i), rd, rg, rp, rh, rr, 0, 0, dt, bn, hn);
      check($sformatf("rand%0d done_at", i), dt, total_len(rd, rg, rr));
    end

    k = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
